// File: rtl/riscv_lsu_if.sv
// Bundle of the request, data-RAM and response signals of the load/store unit.
// master = the LSU itself, slave = the execute/writeback/RAM side.
interface riscv_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, resp_ready,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, resp_ready,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time, word-aligned RAM accesses, optional
// two-word split for accesses crossing a word boundary, extended load results.
module riscv_lsu #(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int ADDR_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  riscv_lsu_if.master      bus,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held while valid&!ready.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    CAP0   = 3'd2,
    ISSUE1 = 3'd3,
    CAP1   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        o_q;
  logic              split_q;
  logic [3:0]        m_hi_q;
  logic [31:0]       d_hi_q;
  logic [31:0]       lo_q;

  logic              req_ready_q;
  logic              mem_en_q;
  logic [3:0]        mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [7:0]        req_m;
  logic [63:0]       req_d;
  logic              req_split;
  logic              req_illegal;

  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] o);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << o;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [63:0] raw,
                                           input logic [1:0] o);
    logic [31:0] r;
    logic [31:0] res;
    r = 32'(raw >> {o, 3'b000});
    case (f3)
      3'b000:  res = {{24{r[7]}}, r[7:0]};
      3'b001:  res = {{16{r[15]}}, r[15:0]};
      3'b100:  res = {24'd0, r[7:0]};
      3'b101:  res = {16'd0, r[15:0]};
      default: res = r;
    endcase
    return res;
  endfunction

  assign req_m       = lane_mask(bus.req_funct3, bus.req_addr[1:0]);
  assign req_d       = {32'd0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
  assign req_split   = |req_m[7:4];
  // Stores have no unsigned variants, so any funct3[2] store is illegal.
  assign req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                       (bus.req_funct3[2] && bus.req_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            o_q         <= bus.req_addr[1:0];
            split_q     <= req_split;
            m_hi_q      <= req_m[7:4];
            d_hi_q      <= req_d[63:32];
            req_ready_q <= 1'b0;
            mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= req_d[31:0];
            if (req_illegal || (req_split && (ALLOW_MISALIGNED == 0))) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state    <= ISSUE0;
              mem_en_q <= 1'b1;
              mem_we_q <= bus.req_we ? req_m[3:0] : 4'h0;
            end
          end
        end
        ISSUE0: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 4'h0;
          state    <= CAP0;
        end
        CAP0: begin
          lo_q <= bus.mem_rdata;
          if (split_q) begin
            state       <= ISSUE1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= we_q ? m_hi_q : 4'h0;
            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
            mem_wdata_q <= d_hi_q;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'd0 : load_ext(f3_q, {32'd0, bus.mem_rdata}, o_q);
          end
        end
        ISSUE1: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 4'h0;
          state    <= CAP1;
        end
        CAP1: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 32'd0 : load_ext(f3_q, {bus.mem_rdata, lo_q}, o_q);
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM strobes are killed in a reset cycle so a reset can never coincide with a write.
  assign bus.mem_en     = mem_en_q & ~rst;
  assign bus.mem_we     = rst ? 4'h0 : mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: one instance with split accesses enabled, one
// rejecting them, sharing a behavioural 1-cycle-latency RAM.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [2:0]  st1, st0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] ram [0:1023];
  logic [31:0] exp_q [$];
  logic [31:0] acc_addr_q [$];
  logic [3:0]  acc_we_q [$];
  logic [31:0] acc_wdata_q [$];
  int          acc_cyc_q [$];

  riscv_lsu_if #(.ADDR_W(32)) if1 ();
  riscv_lsu_if #(.ADDR_W(32)) if0 ();

  riscv_lsu #(.ALLOW_MISALIGNED(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master), .dbg_state(st1));
  riscv_lsu #(.ALLOW_MISALIGNED(0), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master), .dbg_state(st0));

  assign if1.req_valid  = req_valid & ~sel;
  assign if0.req_valid  = req_valid & sel;
  assign if1.req_we     = req_we;
  assign if0.req_we     = req_we;
  assign if1.req_funct3 = req_funct3;
  assign if0.req_funct3 = req_funct3;
  assign if1.req_addr   = req_addr;
  assign if0.req_addr   = req_addr;
  assign if1.req_wdata  = req_wdata;
  assign if0.req_wdata  = req_wdata;
  assign if1.resp_ready = resp_ready;
  assign if0.resp_ready = resp_ready;
  assign if1.mem_rdata  = mem_rdata;
  assign if0.mem_rdata  = mem_rdata;

  wire        mem_en_s     = sel ? if0.mem_en     : if1.mem_en;
  wire [3:0]  mem_we_s     = sel ? if0.mem_we     : if1.mem_we;
  wire [31:0] mem_addr_s   = sel ? if0.mem_addr   : if1.mem_addr;
  wire [31:0] mem_wdata_s  = sel ? if0.mem_wdata  : if1.mem_wdata;
  wire        req_ready_s  = sel ? if0.req_ready  : if1.req_ready;
  wire        resp_valid_s = sel ? if0.resp_valid : if1.resp_valid;
  wire [31:0] resp_rdata_s = sel ? if0.resp_rdata : if1.resp_rdata;
  wire        resp_err_s   = sel ? if0.resp_err   : if1.resp_err;

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM model: read returns the pre-write word one cycle after mem_en
  always @(posedge clk) begin
    if (mem_en_s) begin
      mem_rdata <= ram[mem_addr_s[11:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we_s[b]) ram[mem_addr_s[11:2]][8*b +: 8] = mem_wdata_s[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (mem_en_s) begin
      acc_addr_q.push_back(mem_addr_s);
      acc_we_q.push_back(mem_we_s);
      acc_wdata_q.push_back(mem_wdata_s);
      acc_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: one request, wait for the response, consume it; expectations via exp_q
  int t0;
  task automatic send(input logic s, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    bit got;
    int lat;
    exp_q.push_back(exp_rd);
    acc_addr_q.delete(); acc_we_q.delete(); acc_wdata_q.delete(); acc_cyc_q.delete();
    sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    t0 = cyc;
    check("req_ready_idle", req_ready_s, 1);
    @(negedge clk);
    req_valid = 1'b0;
    got = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid_s) begin
        got = 1;
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("resp_timeout", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      check("resp_latency", lat, exp_lat);
      check("resp_err", resp_err_s, exp_err);
      check("resp_rdata", resp_rdata_s, exp_q.pop_front());
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("resp_valid_drop", resp_valid_s, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    sel = 0; req_valid = 0; req_we = 0; req_funct3 = 3'b010; req_addr = 0; req_wdata = 0;
    resp_ready = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_en", mem_en_s, 0);
    check("rst_mem_we", mem_we_s, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", if1.req_ready, 1);
    check("rst_resp_valid", if1.resp_valid, 0);
    check("rst_resp_rdata", if1.resp_rdata, 0);
    check("rst_resp_err", if1.resp_err, 0);
    check("rst_state", st1, 0);
    check("rst0_req_ready", if0.req_ready, 1);

    // Aligned LW
    ram[32'h100 >> 2] = 32'hDEADBEEF;
    send(0, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 3);
    check("lw_acc_n", acc_addr_q.size(), 1);
    if (acc_addr_q.size() == 1) begin
      check("lw_acc_addr", acc_addr_q[0], 32'h100);
      check("lw_acc_cyc", acc_cyc_q[0] - t0, 1);
      check("lw_acc_we", acc_we_q[0], 0);
    end

    // Byte loads, signed and unsigned
    ram[32'h100 >> 2] = 32'h80112233;
    send(0, 0, 3'b000, 32'h103, 0, 32'hFFFFFF80, 0, 3);
    send(0, 0, 3'b100, 32'h103, 0, 32'h00000080, 0, 3);

    // Aligned halfword store, then reload
    send(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 3);
    check("sh_acc_n", acc_addr_q.size(), 1);
    if (acc_addr_q.size() == 1) begin
      check("sh_acc_addr", acc_addr_q[0], 32'h200);
      check("sh_acc_we", acc_we_q[0], 4'b1100);
      check("sh_acc_wdata_hi", acc_wdata_q[0][31:16], 16'hABCD);
    end
    send(0, 0, 3'b101, 32'h202, 0, 32'h0000ABCD, 0, 3);

    // Split store across 0x100/0x104, then split load
    send(0, 1, 3'b010, 32'h103, 32'h11223344, 32'h0, 0, 5);
    check("sw_split_acc_n", acc_addr_q.size(), 2);
    if (acc_addr_q.size() == 2) begin
      check("sw_split0_addr", acc_addr_q[0], 32'h100);
      check("sw_split0_we", acc_we_q[0], 4'b1000);
      check("sw_split0_wdata", acc_wdata_q[0][31:24], 8'h44);
      check("sw_split1_addr", acc_addr_q[1], 32'h104);
      check("sw_split1_we", acc_we_q[1], 4'b0111);
      check("sw_split1_wdata", acc_wdata_q[1][23:0], 24'h112233);
      check("sw_split1_cyc", acc_cyc_q[1] - t0, 3);
    end
    send(0, 0, 3'b010, 32'h103, 0, 32'h11223344, 0, 5);
    send(0, 0, 3'b001, 32'h102, 0, 32'h00004411, 0, 3);

    // Split load wrapping past the top of the address space
    ram[1023] = 32'hAABBCCDD;
    ram[0]    = 32'h55667788;
    send(0, 0, 3'b010, 32'hFFFFFFFE, 0, 32'h7788AABB, 0, 5);
    if (acc_addr_q.size() == 2) begin
      check("wrap_addr0", acc_addr_q[0], 32'hFFFFFFFC);
      check("wrap_addr1", acc_addr_q[1], 32'h0);
    end else check("wrap_acc_n", acc_addr_q.size(), 2);

    // Illegal funct3 on a store
    send(0, 1, 3'b100, 32'h100, 32'h12345678, 32'h0, 1, 1);
    check("ill_store_acc_n", acc_addr_q.size(), 0);

    // Instance rejecting misaligned accesses
    send(1, 0, 3'b001, 32'h3FF, 0, 32'h0, 1, 1);
    check("mis_acc_n", acc_addr_q.size(), 0);
    send(1, 0, 3'b011, 32'h100, 0, 32'h0, 1, 1);
    check("f3_011_acc_n", acc_addr_q.size(), 0);
    send(1, 0, 3'b010, 32'h100, 0, 32'h44112233, 0, 3);

    // Backpressure: response held for 5 cycles
    sel = 0; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !resp_valid_s; i++) @(negedge clk);
    check("bp_resp_valid", resp_valid_s, 1);
    check("bp_rdata", resp_rdata_s, 32'h44112233);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_hold", resp_valid_s, 1);
      check("bp_rdata_hold", resp_rdata_s, 32'h44112233);
      check("bp_err_hold", resp_err_s, 0);
      check("bp_req_ready", req_ready_s, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_valid_drop", resp_valid_s, 0);
    check("bp_req_ready_back", req_ready_s, 1);

    // Reset during the second access of a split store
    req_we = 1; req_funct3 = 3'b010; req_addr = 32'h106; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_split_issue0_we", mem_we_s, 4'b1100);
    @(negedge clk);
    @(negedge clk);
    check("rst_split_state_issue1", st1, 3);
    check("rst_split_issue1_we", mem_we_s, 4'b0011);
    rst = 1'b1;
    #1;
    check("rst_split_we_gated", mem_we_s, 0);
    check("rst_split_en_gated", mem_en_s, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_split_idle", st1, 0);
    check("rst_split_req_ready", req_ready_s, 1);
    repeat (3) begin
      check("rst_split_no_resp", resp_valid_s, 0);
      @(negedge clk);
    end
    check("rst_split_word0", ram[32'h104 >> 2], 32'hF00D2233);
    check("rst_split_word1", ram[32'h108 >> 2], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit between the execute stage and the data-cache RAM port.
- Accepts one memory request per transaction via valid/ready and issues word-aligned accesses with per-byte write lanes and lane-shifted store data.
- Splits misaligned halfword/word accesses into two word accesses and assembles, shifts and sign/zero-extends load data.
- Returns each completed request to writeback via a valid/ready response; the data RAM has 1-cycle synchronous read latency.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split accesses that cross a word boundary; 0 = reject them with resp_err and no memory access.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- mem_en  output  1  RAM access this cycle.
- mem_we  output  4  byte-lane write enables; lane i = bits [8i+7:8i].
- mem_addr  output  ADDR_W  word-aligned address; bits [1:0] = 0.
- mem_wdata  output  32  lane-shifted store data.
- mem_rdata  input  32  RAM read data, valid one cycle after mem_en.
- resp_valid  output  1  result available.
- resp_ready  input  1  writeback consumes the result.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_err  output  1  misaligned request rejected (ALLOW_MISALIGNED=0) or illegal funct3.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0.
- mem_we and mem_en are gated to 0 combinationally while rst=1, so no write can be issued in a reset cycle.
- States: IDLE, ISSUE0, CAP0, ISSUE1, CAP1, RESP.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata.
  - Illegal funct3 (011, 110, 111; or 1xx with we=1) -> RESP with resp_err=1.
  - Misaligned request with ALLOW_MISALIGNED=0 -> RESP with resp_err=1.
  - Otherwise -> ISSUE0.
- req_ready=0 in every state other than IDLE.
- Lane math: o=addr[1:0]; n=1/2/4 bytes.
  - 8-lane mask M = ((1<<n)-1)<<o.
  - 64-bit data D = wdata<<(8*o).
  - Split iff M[7:4] != 0.
- ISSUE0: mem_en=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_we=we?M[3:0]:0, mem_wdata=D[31:0]. Next state CAP0.
- CAP0: capture mem_rdata into lo. Next state ISSUE1 if split, else RESP.
- ISSUE1: mem_en=1, mem_addr=word0+4 (wraps modulo 2^ADDR_W; 0xFFFFFFFC -> 0x00000000), mem_we=we?M[7:4]:0, mem_wdata=D[63:32]. Next state CAP1.
- CAP1: capture mem_rdata into hi. Next state RESP.
- Load assembly, on entry to RESP: R={hi,lo}>>(8*o).
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W takes R[31:0].
  - resp_rdata is registered, 0 for stores and errors.
- mem_en=0 and mem_we=0 in IDLE, CAP0, CAP1, RESP.
- RESP: resp_valid=1; resp_rdata/resp_err held stable until resp_ready.
  - On resp_ready -> IDLE, and resp_valid drops next cycle.
  - No new request is accepted in the RESP cycle (no bypass).
- Latency from accept edge (cycle T):
  - aligned: ISSUE0 T+1, RESP (resp_valid) T+3.
  - split: ISSUE1 T+3, RESP T+5.
  - error: RESP T+1, no mem_en.
- Stores complete through RESP like loads; a split store writes both words, lower word first.
- Reset mid-transaction: return to IDLE, abandon the transaction, no response. A partially split store leaves the first word written.
- resp_ready held low: the FSM stays in RESP indefinitely; outputs are unchanged.

Test Plan:
- Aligned LW @0x100, RAM word 0x100=0xDEADBEEF -> mem_en with mem_addr=0x100 at T+1; resp_valid at T+3, resp_rdata=0xDEADBEEF, resp_err=0.
- LB @0x103 / LBU @0x103 on word 0x80112233 -> resp_rdata=0xFFFFFF80 / 0x00000080.
- SH @0x202, wdata=0x0000ABCD -> single access: mem_addr=0x200, mem_we=1100, mem_wdata[31:16]=0xABCD; subsequent LHU @0x202 returns 0x0000ABCD.
- Split SW @0x103, wdata=0x11223344 (ALLOW_MISALIGNED=1):
  - first access: addr 0x100, we=1000, wdata[31:24]=0x44.
  - second access: addr 0x104, we=0111, wdata[23:0]=0x112233.
  - LW @0x103 then returns 0x11223344 with resp_valid at T+5.
- ALLOW_MISALIGNED=0, LH @0x3FF -> no mem_en; resp_valid at T+1 with resp_err=1, resp_rdata=0. Same response for funct3=011.
- Backpressure and reset:
  - resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0.
  - rst asserted during ISSUE1 of a split store -> mem_we=0 that cycle, IDLE next cycle, no resp_valid.
